uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver (8N1), the receive-side counterpart of the core's memory-mapped UART transmit path.
- Oversamples the incoming rx line and reassembles bytes.
- Buffers bytes in a small first-word-fall-through FIFO.
- The memory_access stage pops bytes through a valid/pop read interface, and checks sticky error flags for status.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idles high
- rx_pop  input  1  pops FIFO head on a clk edge when rx_valid=1
- err_clear  input  1  clears the sticky error flags
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1
- rx_valid  output  1  FIFO not empty
- rx_full  output  1  FIFO full
- overflow_err  output  1  sticky: a byte was dropped because the FIFO was full
- frame_err  output  1  sticky: stop bit sampled 0
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset, synchronous and active-high:
  - FSM goes to IDLE; FIFO is emptied; counters are zeroed; synchronizer flops are set to 1.
  - rx_valid=0, rx_full=0, overflow_err=0, frame_err=0, busy=0, rx_data=0.
  - Reset asserted mid-frame aborts the frame; no partial byte is ever pushed.
- Input sync: rx passes through a 2-flop synchronizer (reset value 1). All FSM decisions use the synchronized value rs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rs==0, go to START and clear bit_cnt/clk_cnt.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit) and re-sample.
    - rs==1 is a glitch: return to IDLE, no error.
    - rs==0: clear clk_cnt and go to DATA.
  - DATA: sample rs each time clk_cnt reaches CLKS_PER_BIT-1, then clear clk_cnt.
    - Bits are shifted in LSB first.
    - After the 8th sample, go to STOP.
  - STOP: sample after CLKS_PER_BIT-1 cycles, then return to IDLE in the same cycle.
    - Sampled 1: push the byte.
    - Sampled 0: set frame_err and discard the byte.
- Latency:
  - Define t0 as the rx falling edge; sync delay is 2 cycles.
  - rx_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after t0 (the stop-bit sample edge), with the FIFO previously empty.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE is re-entered at mid stop bit, so there is no dead time.
- FIFO behaviour:
  - Circular buffer; read/write pointers are log2(FIFO_DEPTH)+1 bits wide so full and empty are distinguished.
  - rx_data is driven combinationally from the head entry.
  - Pop while empty: ignored; pointers are unchanged.
  - Push while full with no pop in the same cycle: byte dropped, overflow_err set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both take effect; count stays FIFO_DEPTH; no overflow.
  - Push and pop in the same cycle while empty: only the push takes effect. The pop is ignored because rx_valid was 0.
- Sticky flags:
  - err_clear clears overflow_err and frame_err on the next edge.
  - A new error event in the same cycle as err_clear wins: the flag remains 1.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at CLKS_PER_BIT-1.
  - Parity is even: the XOR of the 8 data bits plus the parity bit must be 0.
  - On mismatch: set sticky output parity_err (port present only when the macro is defined), discard the byte, and still traverse STOP.
  - err_clear also clears parity_err.
  - Latency becomes 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Test Plan:
- Single byte, CLKS_PER_BIT=16, rx sends 0xA5:
  - rx_valid rises exactly 154 cycles after the rx fall; rx_data=0xA5.
  - A 1-cycle rx_pop then makes rx_valid=0.
- Glitch: rx low for 4 cycles then high:
  - FSM returns to IDLE; no push; frame_err=0; busy drops within 10 cycles.
- Frame error: send 0x3C with stop bit forced 0:
  - frame_err=1, rx_valid stays 0.
  - err_clear pulse makes frame_err=0 on the next edge.
- Overflow: FIFO_DEPTH=4, send 0x01..0x05 with no pops:
  - rx_full=1 after 0x04; overflow_err=1 after 0x05.
  - Pops return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
- Simultaneous push/pop when full: hold rx_pop=1 on the cycle 0x05 is pushed into a full FIFO:
  - overflow_err stays 0; later pops return 0x02..0x05.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 4 of 0xFF:
  - All outputs return to reset values; no byte appears.
  - A following 0x5A is received correctly.
  - With UART_RX_PARITY_EN defined: 0x07 sent with parity bit 0 sets parity_err=1 and no byte is pushed.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with oversampling FSM and a first-word-fall-through
// receive FIFO. Sticky overflow/frame error flags are cleared by err_clear.
// Optional feature macro UART_RX_PARITY_EN adds an even-parity bit (PARITY state)
// and the sticky parity_err output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_pop,
  input  logic       err_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overflow_err,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state, state_n;
  logic             sync1, rs;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic             push_req;
  logic             frame_set;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_n;
  logic             par_set;
`endif

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, do_pop, do_push, overflow_set;

  // Two-flop synchronizer for the asynchronous rx line (idles high)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      sync1 <= rx;
      rs    <= sync1;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  // Next-state logic, bit sampling and push/error event generation
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    par_set   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rs) begin
          state_n   = S_START;
          clk_cnt_n = '0;
          bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_n = 1'b0;
`endif
        end
      end
      S_START: begin
        if (clk_cnt == CNT_HALF) begin
          if (rs) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            clk_cnt_n = '0;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          shift_n   = {rs, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          state_n   = S_STOP;
          if (^{shift, rs}) begin
            par_bad_n = 1'b1;
            par_set   = 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          // Return to IDLE at mid stop bit so a directly following start bit is caught
          clk_cnt_n = '0;
          state_n   = S_IDLE;
          if (rs) begin
`ifdef UART_RX_PARITY_EN
            push_req = !par_bad;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop       = rx_pop && !empty;
  assign do_push      = push_req && (!full || do_pop);
  assign overflow_set = push_req && full && !do_pop;

  // Receive FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= shift;
        wptr <= wptr + (AW+1)'(1);
      end
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  // Sticky error flags; a new event outranks err_clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      overflow_err <= overflow_set || (overflow_err && !err_clear);
      frame_err    <= frame_set    || (frame_err && !err_clear);
`ifdef UART_RX_PARITY_EN
      parity_err   <= par_set      || (parity_err && !err_clear);
`endif
    end
  end

  assign rx_data  = mem[rptr[AW-1:0]];
  assign rx_valid = !empty;
  assign rx_full  = full;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Frames are serialised by a task that
// also pushes the expected outcome into a queue; a monitor pops the DUT FIFO and
// compares against the queue. Honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NEXTRA = 1;
`else
  localparam int NEXTRA = 0;
`endif
  // Cycles from the first clock edge that sees rx low to the edge raising rx_valid
  localparam int LAT = 2 + CPB / 2 + (9 + NEXTRA) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       err_clear = 1'b0;
  logic       mon_pop = 1'b0;
  logic       man_pop = 1'b0;
  logic       rx_pop;
  logic [7:0] rx_data;
  logic       rx_valid, rx_full, overflow_err, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  assign rx_pop = mon_pop | man_pop;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_pop       (rx_pop),
    .err_clear    (err_clear),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_full      (rx_full),
    .overflow_err (overflow_err),
    .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  bit         pop_en = 1'b0;
  bit         model_frame = 1'b0;
  bit         model_ovf = 1'b0;
  bit         model_par = 1'b0;
  int unsigned last_c0 = 0;
  int unsigned last_rise = 0;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: no model update, 1: normal accept/drop rules, 2: accepted regardless of fullness
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip, input int mode);
    last_c0 = cyc + 1;
    if (mode == 2) begin
      exp_q.push_back(d);
    end else if (mode == 1) begin
      bit drop;
      drop = 1'b0;
      if (!stop_bit) begin
        model_frame = 1'b1;
        drop = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (par_flip) begin
        model_par = 1'b1;
        drop = 1'b1;
      end
`endif
      if (!drop) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else model_ovf = 1'b1;
      end
    end
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    idle(CPB);
`endif
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    pop_en = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    exp_q.delete();
    model_frame = 1'b0;
    model_ovf = 1'b0;
    model_par = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    idle(3);
    check(name, exp_q.size(), 0);
    check({name, "_valid"}, rx_valid, 0);
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
  endtask

  // Scoreboard monitor: pops whatever the DUT presents and compares with the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (pop_en && rx_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte (cycle %0d)", rx_data, cyc);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
        mon_pop = 1'b1;
        @(negedge clk);
        mon_pop = 1'b0;
      end
    end
  end

  // Record the cycle of each rx_valid rising edge
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_valid) last_rise = cyc;
      prev_valid = rx_valid;
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, summary follows");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned c0;
    logic [7:0] d;
    bit bad;
    bit flip;
    int gap;

    // Reset state
    idle(3);
    check("rst_valid", rx_valid, 0);
    check("rst_full", rx_full, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_frame", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_data", rx_data, 0);
    rst = 1'b0;
    idle(4);

    // Single byte latency
    pop_en = 1'b1;
    last_rise = 0;
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    idle(4);
    check("latency", last_rise - last_c0, LAT);
    drain("single");

    // Start-bit glitch
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3);
    check("glitch_busy", busy, 1);
    for (int i = 0; i < 10 && busy; i++) idle(1);
    check("glitch_busy_drop", busy, 0);
    check("glitch_frame", frame_err, 0);
    check("glitch_valid", rx_valid, 0);

    // Frame error and clearing
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    idle(20);
    check("frame_err_set", frame_err, model_frame);
    check("frame_valid", rx_valid, 0);
    clear_errors();
    check("frame_err_clear", frame_err, 0);

    // err_clear held across a new frame error: the error wins
    c0 = cyc + 1;
    fork
      send_frame(8'h3C, 1'b0, 1'b0, 1);
      begin
        wait_until(c0 + LAT - 4);
        err_clear = 1'b1;
        wait_until(c0 + LAT);
        err_clear = 1'b0;
        check("frame_err_wins", frame_err, 1);
      end
    join
    idle(20);
    clear_errors();
    check("frame_err_clear2", frame_err, 0);

    // Overflow with no pops
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1);
    check("full_after_4", rx_full, 1);
    check("ovf_after_4", overflow_err, 0);
    send_frame(8'h05, 1'b1, 1'b0, 1);
    check("ovf_after_5", overflow_err, model_ovf);
    check("full_after_5", rx_full, 1);
    pop_en = 1'b1;
    drain("overflow_drain");
    check("overflow_full_clear", rx_full, 0);

    // Push and pop in the same cycle while full
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1);
    c0 = cyc + 1;
    fork
      send_frame(8'h05, 1'b1, 1'b0, 2);
      begin
        wait_until(c0 + LAT - 1);
        check("simul_head", rx_data, exp_q.pop_front());
        man_pop = 1'b1;
        idle(1);
        man_pop = 1'b0;
        check("simul_ovf", overflow_err, 0);
        check("simul_full", rx_full, 1);
      end
    join
    idle(4);
    check("simul_ovf_later", overflow_err, model_ovf);
    pop_en = 1'b1;
    drain("simul_drain");

    // Reset in the middle of a frame
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    idle(20);
    send_frame(8'h77, 1'b1, 1'b0, 1);
    check("pre_rst_valid", rx_valid, 1);
    check("pre_rst_frame", frame_err, 1);
    c0 = cyc + 1;
    fork
      send_frame(8'hFF, 1'b1, 1'b1, 0);
      begin
        wait_until(c0 + 5 * CPB + 8);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        model_frame = 1'b0;
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_frame", frame_err, 0);
        check("midrst_busy", busy, 0);
        check("midrst_full", rx_full, 0);
      end
    join
    idle(30);
    check("midrst_no_byte", rx_valid, 0);
    pop_en = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 1);
    drain("after_rst");

`ifdef UART_RX_PARITY_EN
    // Bad parity: 0x07 with parity bit 0
    send_frame(8'h07, 1'b1, 1'b1, 1);
    idle(4);
    check("parity_err_set", parity_err, model_par);
    check("parity_no_byte", rx_valid, 0);
    clear_errors();
    check("parity_err_clear", parity_err, 0);
    model_par = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1);
    drain("parity_good");
`endif

    // Randomised frames, back-to-back or gapped, occasional line errors
    do_reset();
    pop_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      bad  = ($urandom_range(7) == 0);
      flip = ($urandom_range(7) == 0);
      gap  = bad ? 20 : int'($urandom_range(6));
      send_frame(d, !bad, flip, 1);
      idle(gap);
    end
    idle(20);
    drain("random_drain");
    check("random_frame", frame_err, model_frame);
    check("random_ovf", overflow_err, model_ovf);
`ifdef UART_RX_PARITY_EN
    check("random_parity", parity_err, model_par);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
